// File: rtl/pipelined_reduce_gate.sv
// pipelined_reduce_gate: reduces a WIDTH-bit bus to one bit (AND/OR/XOR,
// optionally inverted) through a registered radix-RADIX tree. A valid bit
// rides alongside each beat, and a clock enable stalls the whole pipeline.
module pipelined_reduce_gate #(
  parameter int WIDTH  = 13,
  parameter int RADIX  = 4,
  parameter int FUNC   = 0,
  parameter int INVERT = 0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             CE,
  input  logic             VI,
  input  logic [WIDTH-1:0] A,
  output logic             VO,
  output logic             Z0
);

  // Width left after one tree level.
  function automatic int next_w(input int w);
    return (w + RADIX - 1) / RADIX;
  endfunction

  // Width entering tree level k (level 0 sees the raw bus).
  function automatic int stage_in_w(input int k);
    int w;
    w = WIDTH;
    for (int i = 0; i < k; i++) begin
      w = next_w(w);
    end
    return w;
  endfunction

  // Number of registered levels needed to reach one bit; at least one.
  function automatic int calc_lat();
    int w;
    int l;
    w = next_w(WIDTH);
    l = 1;
    while (w > 1) begin
      w = next_w(w);
      l++;
    end
    return l;
  endfunction

  localparam int   LAT   = calc_lat();
  // Identity element used to pad a partial last group: 1 for AND, 0 otherwise.
  localparam logic IDENT = (FUNC == 0);

  // Reject parameter values outside the supported range at elaboration.
  if (FUNC < 0 || FUNC > 2) begin : g_bad_func
    $error("pipelined_reduce_gate: FUNC must be 0 (AND), 1 (OR) or 2 (XOR)");
  end
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("pipelined_reduce_gate: WIDTH must be in 1..256");
  end
  if (RADIX < 2 || RADIX > 8) begin : g_bad_radix
    $error("pipelined_reduce_gate: RADIX must be in 2..8");
  end

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    localparam int W_IN  = stage_in_w(gi);
    localparam int W_OUT = stage_in_w(gi + 1);
    localparam int PADW  = W_OUT * RADIX;
    // Only the last level applies the optional inversion, so Z0 stays a bare flop.
    localparam bit DO_INV = (gi == LAT - 1) && (INVERT != 0);

    logic [W_IN-1:0]  in_vec;
    logic             valid_in;
    logic [PADW-1:0]  pad_vec;
    logic [W_OUT-1:0] red_vec;
    logic [W_OUT-1:0] data_d;
    logic [W_OUT-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    if (gi == 0) begin : g_first
      assign in_vec   = A;
      assign valid_in = VI;
    end else begin : g_next
      assign in_vec   = g_stage[gi-1].data_q;
      assign valid_in = g_stage[gi-1].valid_q;
    end

    // Pad the level input up to a whole number of groups with the identity element.
    always_comb begin
      pad_vec             = {PADW{IDENT}};
      pad_vec[W_IN-1:0]   = in_vec;
    end

    for (genvar gj = 0; gj < W_OUT; gj++) begin : g_node
      if (FUNC == 0) begin : g_and
        assign red_vec[gj] = &pad_vec[gj*RADIX +: RADIX];
      end else if (FUNC == 1) begin : g_or
        assign red_vec[gj] = |pad_vec[gj*RADIX +: RADIX];
      end else begin : g_xor
        assign red_vec[gj] = ^pad_vec[gj*RADIX +: RADIX];
      end
    end

    // Next state: advance data and valid together on enabled cycles, hold otherwise.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (CE) begin
        data_d  = DO_INV ? ~red_vec : red_vec;
        valid_d = valid_in;
      end
    end

    // Level registers, cleared asynchronously so in-flight beats vanish on reset.
    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end
  end

  assign Z0 = g_stage[LAT-1].data_q[0];
  assign VO = g_stage[LAT-1].valid_q;

endmodule
